// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared state encoding and default width for the sequential multiplier
package mult_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} mult_state_t;

  localparam int DEFAULT_WIDTH = 9;

endpackage

// File: rtl/mult_abs.sv
// rtl/mult_abs.sv - operand magnitude/sign split; the most negative value maps to 2^(WIDTH-1)
module mult_abs
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] value,
  input  logic             is_signed,
  output logic [WIDTH-1:0] magnitude,
  output logic             sign
);

  assign sign      = is_signed & value[WIDTH-1];
  assign magnitude = sign ? (-value) : value;

endmodule

// File: rtl/seq_multiplier.sv
// rtl/seq_multiplier.sv - radix-2 shift-add multiplier with valid/ready handshakes
// Optional zero-multiplier early termination: SEQ_MULT_EARLY_TERM_EN.
module seq_multiplier
  import mult_pkg::*;
#(
  parameter  int WIDTH  = DEFAULT_WIDTH,
  localparam int PROD_W = 2 * WIDTH,
  localparam int CNT_W  = $clog2(WIDTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic              is_signed,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] y
);

  mult_state_t       state;
  logic [WIDTH-1:0]  a_mag;
  logic [WIDTH-1:0]  b_mag;
  logic              a_neg;
  logic              b_neg;
  logic [PROD_W-1:0] mcand;
  logic [PROD_W-1:0] acc;
  logic [PROD_W-1:0] addend;
  logic [WIDTH-1:0]  mplr;
  logic [CNT_W-1:0]  cnt;
  logic              neg;
  logic              finish;

  mult_abs #(.WIDTH(WIDTH)) u_abs_a (
    .value     (a),
    .is_signed (is_signed),
    .magnitude (a_mag),
    .sign      (a_neg)
  );

  mult_abs #(.WIDTH(WIDTH)) u_abs_b (
    .value     (b),
    .is_signed (is_signed),
    .magnitude (b_mag),
    .sign      (b_neg)
  );

  // mcand is pre-shifted each step, so it always equals |a| << (WIDTH - cnt)
  assign addend = mplr[0] ? mcand : '0;

`ifdef SEQ_MULT_EARLY_TERM_EN
  assign finish = (cnt == '0) || (mplr == '0);
`else
  assign finish = (cnt == '0);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      y         <= '0;
      cnt       <= '0;
      acc       <= '0;
      mcand     <= '0;
      mplr      <= '0;
      neg       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            mcand    <= PROD_W'(a_mag);
            mplr     <= b_mag;
            neg      <= a_neg ^ b_neg;
            acc      <= '0;
            cnt      <= CNT_W'(WIDTH);
            in_ready <= 1'b0;
            state    <= BUSY;
          end
        end
        BUSY: begin
          if (finish) begin
            y         <= neg ? (-acc) : acc;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            acc   <= acc + addend;
            mcand <= mcand << 1;
            mplr  <= mplr >> 1;
            cnt   <= cnt - CNT_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// tb/tb_seq_multiplier.sv - scoreboard bench for seq_multiplier against an arithmetic reference
module tb_seq_multiplier;

  localparam int W  = 9;
  localparam int PW = 2 * W;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          is_signed;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] y;

  seq_multiplier #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .is_signed (is_signed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [PW-1:0] prod;
    int            edge_n;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   fails  = 0;
  int   cycle  = 0;
  logic prev_ov = 1'b0;

  always @(posedge clk) cycle = cycle + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    fails++;
    $display("FAIL %s (cycle %0d)", name, cycle);
  endtask

  function automatic logic [PW-1:0] ref_prod(input logic [W-1:0] x, input logic [W-1:0] z,
                                             input logic s);
    longint xi;
    longint zi;
    xi = s ? longint'($signed(x)) : longint'(x);
    zi = s ? longint'($signed(z)) : longint'(z);
    return PW'(xi * zi);
  endfunction

  function automatic int ref_latency(input logic [W-1:0] z, input logic s);
    longint zi;
    int     hi;
    zi = s ? longint'($signed(z)) : longint'(z);
    if (zi < 0) zi = -zi;
    hi = -1;
    for (int i = 0; i < 40; i++) if (((zi >> i) & 1) == 1) hi = i;
`ifdef SEQ_MULT_EARLY_TERM_EN
    return (hi < 0) ? 1 : hi + 2;
`else
    return (hi >= -1) ? W + 1 : 0;
`endif
  endfunction

  // Monitor: checks every DONE cycle against the head of the scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && out_valid) begin
        if (q.size() == 0) begin
          flag("unexpected_out_valid");
        end else begin
          if (!prev_ov) check("latency_edge", 64'(cycle), 64'(q[0].edge_n));
          check("product", 64'(y), 64'(q[0].prod));
          check("in_ready_low_in_done", 64'(in_ready), 64'd0);
          if (out_ready) void'(q.pop_front());
        end
      end
      prev_ov = out_valid & ~rst;
    end
  end

  task automatic issue(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic s);
    int t;
    t = 0;
    @(negedge clk);
    a = ai; b = bi; is_signed = s; in_valid = 1'b1;
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) flag("accept_timeout");
    q.push_back('{ref_prod(ai, bi, s), cycle + 1 + ref_latency(bi, s)});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    is_signed = 1'($urandom);
  endtask

  task automatic wait_done(input bit rand_ready);
    int t;
    t = 0;
    while ((q.size() != 0 || out_valid) && t < 300) begin
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      t++;
    end
    if (t >= 300) flag("result_timeout");
    out_ready = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout (cycle %0d)", cycle);
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] dir_a [9] = '{9'd2, 9'd4, 9'h100, 9'h1FF, 9'd511, 9'd511, 9'd7, 9'd7, 9'd7};
    logic [W-1:0] dir_b [9] = '{9'd2, 9'd4, 9'h100, 9'd255, 9'd511, 9'd511, 9'd0, 9'd1, 9'd0};
    logic         dir_s [9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    int t;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; is_signed = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_y", 64'(y), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Spot-check the reference model against hand-derived products
    check("ref_signed_min_sq", 64'(ref_prod(9'h100, 9'h100, 1'b1)), 64'd65536);
    check("ref_neg_one_255", 64'(ref_prod(9'h1FF, 9'd255, 1'b1)), 64'h3FF01);
    check("ref_unsigned_max", 64'(ref_prod(9'd511, 9'd511, 1'b0)), 64'd261121);

    for (int i = 0; i < 9; i++) begin
      issue(dir_a[i], dir_b[i], dir_s[i]);
      wait_done(1'b0);
    end

    // Backpressure with a stray in_valid pulse while DONE
    out_ready = 1'b0;
    issue(9'd13, 9'd11, 1'b0);
    t = 0;
    while (!out_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!out_valid) flag("stall_out_valid_timeout");
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      if (i == 1) begin
        a = 9'd1; b = 9'd1; is_signed = 1'b0; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      check("stall_out_valid_held", 64'(out_valid), 64'd1);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_done(1'b0);
    repeat (15) @(negedge clk);

    // Reset three cycles into an operation discards it
    issue(9'd5, 9'd6, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midop_reset_out_valid", 64'(out_valid), 64'd0);
    check("midop_reset_y", 64'(y), 64'd0);
    check("midop_reset_in_ready", 64'(in_ready), 64'd1);
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    issue(9'd3, 9'd5, 1'b0);
    wait_done(1'b0);

    for (int i = 0; i < 1000; i++) begin
      issue(W'($urandom), W'($urandom), 1'($urandom));
      wait_done(1'($urandom));
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 64'(q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/seq_multiplier.md
Name: seq_multiplier

Overview:
- Parametrised, multi-cycle radix-2 shift-add multiplier. It is the sequential successor to the combinational 9-bit multiplier.
- Adds a valid/ready handshake on input and output, and a per-operation signed/unsigned mode.
- Sits between datapath producers and consumers that can tolerate a latency of WIDTH+1 cycles in exchange for a single adder.

Parameters:
- WIDTH, 9, operand width in bits; legal range 2..32.
- PROD_W, 2*WIDTH, product width; derived, not overridable.
- CNT_W, $clog2(WIDTH+1), iteration counter width; derived.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  operands valid
- in_ready  out  1  block can accept operands
- a  in  WIDTH  multiplicand
- b  in  WIDTH  multiplier
- is_signed  in  1  1 = two's-complement operands, 0 = unsigned; sampled at accept
- out_valid  out  1  product valid
- out_ready  in  1  consumer accepts product
- y  out  PROD_W  product

Behaviour:
- Reset (async, rst=1): state=IDLE, in_ready=1, out_valid=0, y=0, counter=0, internal accumulators=0. Asserting rst mid-operation discards the operation; no out_valid follows.
- States: IDLE, BUSY, DONE.
- in_ready equals 1 only in IDLE. out_valid equals 1 only in DONE.
- IDLE: on in_valid && in_ready at edge N:
  - latch |a| and |b| as unsigned magnitudes; magnitudes are taken only when is_signed=1 and the MSB is 1;
  - latch neg = is_signed & (a[MSB] ^ b[MSB]);
  - clear the accumulator, set counter=WIDTH, go to BUSY.
- Magnitude of the most negative value (e.g. -256 at WIDTH=9) is 2^(WIDTH-1) and is held correctly in WIDTH unsigned bits.
- BUSY, each cycle:
  - if the multiplier LSB is 1, add the multiplicand shifted by (WIDTH-counter) into the PROD_W accumulator;
  - shift the multiplier right, decrement the counter.
  - When the counter reaches 0, register y = neg ? -acc : acc (PROD_W two's complement) and go to DONE.
- Latency without the optional feature: out_valid rises at edge N+WIDTH+1, fixed and data-independent.
- DONE: y and out_valid are held stable until out_ready=1. On out_valid && out_ready, go to IDLE; in_ready rises the next cycle, with no same-cycle re-accept.
- out_ready while not in DONE is ignored. in_valid outside IDLE is ignored; operands are not latched.
- y holds its last value after handshake until the next result is written.
- Result is exact: no overflow for any operand pair in either mode.
  - Signed range: (-2^(W-1))^2 = 2^(2W-2), which fits in PROD_W signed.
  - Unsigned range: (2^W-1)^2 < 2^(2W).

Optional Feature:
- SEQ_MULT_EARLY_TERM_EN defined: in BUSY, if the remaining shifted multiplier is all-zero, finalise y immediately and go to DONE.
  - Latency becomes 1 + (index of the highest set bit of |b|) + 1 edges.
  - b=0 reaches DONE at edge N+1.
- Not defined: latency is always WIDTH+1; the zero-detect logic is absent.
- Results are identical in both builds.

Decomposition:
- Package mult_pkg holds:
  - typedef enum logic [1:0] {IDLE, BUSY, DONE} mult_state_t;
  - localparam DEFAULT_WIDTH = 9.
- One sub-module is natural: mult_abs (combinational, WIDTH param; inputs value and is_signed; outputs magnitude and sign). It is instanced twice for a and b.
- Accumulator, counter and FSM stay in seq_multiplier.

Test Plan:
- Unsigned basic, WIDTH=9: a=2, b=2, is_signed=0 -> y=4, out_valid at edge N+10. Then a=4, b=4 -> y=16.
- Signed extremes: a=-256 (9'h100), b=-256, is_signed=1 -> y=65536. Then a=-1, b=255 -> y=-255 (18'h3FF01).
- Unsigned max: a=511, b=511, is_signed=0 -> y=261121; the same bits with is_signed=1 -> y=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> y stable and in_ready=0 throughout. Pulse in_valid during the stall -> no accept; the next result is still from the original operands.
- Reset mid-BUSY: assert rst 3 cycles after accept -> out_valid=0, y=0, in_ready=1 immediately. A fresh a=3, b=5 then yields y=15.
- SEQ_MULT_EARLY_TERM_EN:
  - a=7, b=0 -> y=0 at edge N+1;
  - a=7, b=1 -> y=7 at edge N+2;
  - random 1000 signed/unsigned pairs match a reference model in both builds.
